dmem_mmio_responder: RTL

- Responder on the processor's data-memory port: address, write data, write enable out from the core; read data back.
- Decodes each access. RAM-region accesses pass through to the synchronous data RAM.
- The top 256-byte page is served locally by a free-running timer with compare/interrupt and a console TX FIFO that drains over a valid/ready handshake.
- Sits in Wrapper between the processor and the dmem instance.

---
 rtl/dmem_mmio_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: forwards RAM-region accesses to the synchronous
// data RAM and serves the top 256-byte page with a timer and a console TX FIFO.
module dmem_mmio_responder #(
  parameter int unsigned RAM_ADDR_BITS = 12,
  parameter int unsigned TX_DEPTH      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address_dmem,
  input  logic [31:0]              data,
  input  logic                     wren,
  output logic [31:0]              q_dmem,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_data,
  output logic                     ram_wren,
  input  logic [31:0]              ram_q,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     irq
);

  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [7:0] OFF_COUNT  = 8'hF0;
  localparam logic [7:0] OFF_CMP    = 8'hF4;
  localparam logic [7:0] OFF_STATUS = 8'hF8;
  localparam logic [7:0] OFF_TXDATA = 8'hFC;

  logic          w_mmio;
  logic [7:0]    w_off;
  logic          w_wr_count;
  logic          w_wr_cmp;
  logic          w_wr_status;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_match_cond;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;

  logic [31:0]   r_count;
  logic [31:0]   r_cmp;
  logic          r_match;
  logic          r_ovf;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_sel_mmio;
  logic [31:0]   r_rdata;
  logic [7:0]    r_mem [TX_DEPTH];

  // Address decode and RAM passthrough; MMIO writes never reach the RAM.
  assign w_mmio   = (address_dmem[31:8] == 24'hFFFFFF);
  assign w_off    = address_dmem[7:0];
  assign ram_addr = address_dmem[RAM_ADDR_BITS-1:0];
  assign ram_data = data;
  assign ram_wren = wren && !w_mmio;

  assign w_wr_count  = wren && w_mmio && (w_off == OFF_COUNT);
  assign w_wr_cmp    = wren && w_mmio && (w_off == OFF_CMP);
  assign w_wr_status = wren && w_mmio && (w_off == OFF_STATUS);
  assign w_push_req  = wren && w_mmio && (w_off == OFF_TXDATA);

  assign w_full       = (r_cnt == CW'(TX_DEPTH));
  assign w_empty      = (r_cnt == '0);
  assign w_pop        = !w_empty && tx_ready;
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_match_cond = (r_cmp != '0) && (r_count == r_cmp);

  assign w_status = {16'h0000, 8'(r_cnt), 4'h0, r_ovf, w_empty, w_full, r_match};

  // Local read mux, sampled from pre-edge register values.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_COUNT:  w_rdata = r_count;
      OFF_CMP:    w_rdata = r_cmp;
      OFF_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_cmp      <= '0;
      r_match    <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_sel_mmio <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_sel_mmio <= w_mmio;
      r_rdata    <= w_rdata;
      r_count    <= w_wr_count ? data : r_count + 32'd1;
      if (w_wr_cmp) begin
        r_cmp <= data;
      end
      // Sticky flags: a coincident set beats a clear.
      if (w_match_cond) begin
        r_match <= 1'b1;
      end else if (w_wr_status && data[0]) begin
        r_match <= 1'b0;
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && data[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage is not reset; only the pointers define its contents.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data[7:0];
    end
  end

  assign q_dmem   = r_sel_mmio ? r_rdata : ram_q;
  assign tx_data  = r_mem[r_rd_ptr];
  assign tx_valid = !w_empty;
  assign irq      = r_match;

endmodule
